// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;
   localparam int WIDTH = 32;
   localparam int ITERS = 32;
   localparam int CNT_W = 6;

   typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} multdiv_state_t;
   typedef enum logic [1:0] {NOP, ADD, SUB} booth_op_t;

   // Radix-2 Booth recoding of {multiplier lsb, q-1}.
   function automatic booth_op_t booth_decode(input logic [1:0] pair);
      case (pair)
         2'b01:   return ADD;
         2'b10:   return SUB;
         default: return NOP;
      endcase
   endfunction
endpackage

// File: rtl/multdiv_cla.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, carries rippled between groups.
module multdiv_cla (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        cin,
   output logic [31:0] sum,
   output logic        cout
);
   logic [31:0] p, g;
   logic [32:0] c;

   assign p    = a ^ b;
   assign g    = a & b;
   assign c[0] = cin;

   for (genvar gi = 0; gi < 8; gi++) begin : g_grp
      localparam int L = gi * 4;
      assign c[L+1] = g[L] | (p[L] & c[L]);
      assign c[L+2] = g[L+1] | (p[L+1] & g[L]) | (p[L+1] & p[L] & c[L]);
      assign c[L+3] = g[L+2] | (p[L+2] & g[L+1]) | (p[L+2] & p[L+1] & g[L])
                    | (p[L+2] & p[L+1] & p[L] & c[L]);
      assign c[L+4] = g[L+3] | (p[L+3] & g[L+2]) | (p[L+3] & p[L+2] & g[L+1])
                    | (p[L+3] & p[L+2] & p[L+1] & g[L])
                    | (p[L+3] & p[L+2] & p[L+1] & p[L] & c[L]);
   end

   assign sum  = p ^ c[31:0];
   assign cout = c[32];
endmodule

// File: rtl/multdiv_counter.sv
// Iteration counter: clears on start, steps once per iteration, holds at ITERS-1.
module multdiv_counter
   import multdiv_pkg::*;
(
   input  logic clock,
   input  logic reset_n,
   input  logic clr,
   input  logic en,
   output logic term
);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign term = (cnt_q == CNT_W'(ITERS - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clr)
         cnt_d = '0;
      else if (en && !term)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end
endmodule

// File: rtl/multdiv.sv
// Iterative signed 32-bit Booth multiply / non-restoring divide, one step per clock.
// Define MULTDIV_EARLY_TERM_EN to finish divide-by-zero one edge after the start.
module multdiv
   import multdiv_pkg::*;
(
   input  logic        clock,
   input  logic        reset_n,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_resultRDY,
   output logic        busy
);
`ifdef MULTDIV_EARLY_TERM_EN
   localparam logic EARLY_TERM = 1'b1;
`else
   localparam logic EARLY_TERM = 1'b0;
`endif

   multdiv_state_t   state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d, mq_q, mq_d, m_q, m_d, res_q, res_d;
   logic             ext_q, ext_d, fin_q, fin_d, qneg_q, qneg_d, dz_q, dz_d;
   logic             exc_q, exc_d, rdy_q, rdy_d, busy_q, busy_d;

   logic             start, invert, sum_top, add_cout, ntop;
   logic             cnt_clr, cnt_en, cnt_term;
   logic [WIDTH-1:0] add_a, add_b, add_src, add_sum, nacc;
   booth_op_t        op;

   multdiv_counter u_cnt (
      .clock(clock), .reset_n(reset_n), .clr(cnt_clr), .en(cnt_en), .term(cnt_term)
   );

   multdiv_cla u_add (
      .a(add_a), .b(add_b), .cin(invert), .sum(add_sum), .cout(add_cout)
   );

   // Adder operand steering: start-time |A|, final quotient negation, or one iteration.
   always_comb begin
      start   = ctrl_MULT | ctrl_DIV;
      op      = booth_decode({mq_q[0], ext_q});
      add_a   = acc_q;
      add_src = m_q;
      invert  = (op == SUB);
      if (start) begin
         add_a   = '0;
         add_src = data_operandA;
         invert  = 1'b1;
      end else if (state_q == DIV && fin_q) begin
         add_a   = '0;
         add_src = mq_q;
         invert  = 1'b1;
      end else if (state_q == DIV) begin
         add_a   = {acc_q[WIDTH-2:0], mq_q[WIDTH-1]};
         add_src = m_q;
         // Subtract |B| when the partial remainder is non-negative, add it otherwise.
         invert  = ~ext_q ^ m_q[WIDTH-1];
      end
      add_b = invert ? ~add_src : add_src;
   end

   // Bit 32 of the 33-bit sum, so a -2^31 operand cannot corrupt the sign.
   assign sum_top = acc_q[WIDTH-1] ^ add_b[WIDTH-1] ^ add_cout;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      mq_d    = mq_q;
      m_d     = m_q;
      ext_d   = ext_q;
      fin_d   = fin_q;
      qneg_d  = qneg_q;
      dz_d    = dz_q;
      res_d   = res_q;
      exc_d   = exc_q;
      rdy_d   = 1'b0;
      busy_d  = 1'b0;
      cnt_clr = 1'b0;
      cnt_en  = 1'b0;
      nacc    = (op == NOP) ? acc_q : add_sum;
      ntop    = (op == NOP) ? acc_q[WIDTH-1] : sum_top;

      if (start) begin
         state_d = ctrl_MULT ? MULT : DIV;
         cnt_clr = 1'b1;
         busy_d  = 1'b1;
         acc_d   = '0;
         ext_d   = 1'b0;
         m_d     = ctrl_MULT ? data_operandA : data_operandB;
         mq_d    = ctrl_MULT ? data_operandB
                             : (data_operandA[WIDTH-1] ? add_sum : data_operandA);
         qneg_d  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         dz_d    = (data_operandB == '0);
         fin_d   = EARLY_TERM & ~ctrl_MULT & (data_operandB == '0);
      end else begin
         case (state_q)
            MULT, DIV: begin
               if (fin_q) begin
                  state_d = DONE;
                  rdy_d   = 1'b1;
                  if (state_q == MULT) begin
                     res_d = mq_q;
                     exc_d = (acc_q != {WIDTH{mq_q[WIDTH-1]}});
                  end else begin
                     res_d = dz_q ? '0 : (qneg_q ? add_sum : mq_q);
                     // Only 0x80000000 / -1 yields a positive quotient of 2^31.
                     exc_d = dz_q | (~qneg_q & mq_q[WIDTH-1]);
                  end
               end else begin
                  cnt_en = 1'b1;
                  fin_d  = cnt_term;
                  busy_d = 1'b1;
                  if (state_q == MULT) begin
                     acc_d = {ntop, nacc[WIDTH-1:1]};
                     mq_d  = {nacc[0], mq_q[WIDTH-1:1]};
                     ext_d = mq_q[0];
                  end else begin
                     acc_d = add_sum;
                     ext_d = sum_top;
                     mq_d  = {mq_q[WIDTH-2:0], ~sum_top};
                  end
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         mq_q    <= '0;
         m_q     <= '0;
         ext_q   <= 1'b0;
         fin_q   <= 1'b0;
         qneg_q  <= 1'b0;
         dz_q    <= 1'b0;
         res_q   <= '0;
         exc_q   <= 1'b0;
         rdy_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         mq_q    <= mq_d;
         m_q     <= m_d;
         ext_q   <= ext_d;
         fin_q   <= fin_d;
         qneg_q  <= qneg_d;
         dz_q    <= dz_d;
         res_q   <= res_d;
         exc_q   <= exc_d;
         rdy_q   <= rdy_d;
         busy_q  <= busy_d;
      end
   end

   assign data_result    = res_q;
   assign data_exception = exc_q;
   assign data_resultRDY = rdy_q;
   assign busy           = busy_q;
endmodule

// File: tb/tb_multdiv.sv
// Directed bench for multdiv: arithmetic reference model plus per-cycle output compare.
module tb_multdiv;
`ifdef MULTDIV_EARLY_TERM_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic [31:0] op_a = '0, op_b = '0;
   logic        c_mul = 1'b0, c_div = 1'b0;
   logic [31:0] data_result;
   logic        data_exception, data_resultRDY, busy;

   always #5 clock = ~clock;

   multdiv dut (
      .clock(clock), .reset_n(reset_n),
      .data_operandA(op_a), .data_operandB(op_b),
      .ctrl_MULT(c_mul), .ctrl_DIV(c_div),
      .data_result(data_result), .data_exception(data_exception),
      .data_resultRDY(data_resultRDY), .busy(busy)
   );

   int n_cmp = 0, n_fail = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference arithmetic straight from the signed-integer definitions.
   function automatic void ref_op(input bit mul, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output bit e);
      int     sa, sb, q;
      longint p;
      sa = a;
      sb = b;
      if (mul) begin
         p = longint'(sa) * longint'(sb);
         r = p[31:0];
         e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      end else if (b == 32'd0) begin
         r = 32'd0; e = 1'b1;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         r = 32'h8000_0000; e = 1'b1;
      end else begin
         q = sa / sb;
         r = q; e = 1'b0;
      end
   endfunction

   // Timeline model: an op completes a fixed number of edges after its start edge.
   bit          m_pend = 0, m_rdy = 0, m_exc = 0, m_pexc = 0, m_full = 0;
   logic [31:0] m_res = '0, m_pres = '0;
   int          m_left = 0, m_since = 0;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_pend = 0; m_rdy = 0; m_res = '0; m_exc = 0; m_since = 0; m_left = 0;
      end else begin
         m_rdy = 0;
         if (c_mul || c_div) begin
            ref_op(c_mul, op_a, op_b, m_pres, m_pexc);
            m_left  = (!c_mul && op_b == 32'd0 && EARLY) ? 1 : 33;
            m_full  = (m_left == 33);
            m_pend  = 1;
            m_since = 0;
         end else if (m_pend) begin
            m_since++;
            m_left--;
            if (m_left == 0) begin
               m_pend = 0; m_rdy = 1; m_res = m_pres; m_exc = m_pexc;
            end
         end
      end
   end

   always @(negedge clock) begin
      if (chk_en) begin
         chk("cyc_rdy", 32'(data_resultRDY), 32'(m_rdy));
         chk("cyc_result", data_result, m_res);
         chk("cyc_exc", 32'(data_exception), 32'(m_exc));
         if (!m_pend)
            chk("cyc_busy_idle", 32'(busy), 32'd0);
         else if (m_full && m_since >= 1)
            chk("cyc_busy_run", 32'(busy), 32'd1);
      end
   end

   // Caller is positioned just after a rising edge; the next edge is the start edge.
   task automatic start_op(input bit mul, input bit div, input logic [31:0] a, input logic [31:0] b);
      op_a = a; op_b = b; c_mul = mul; c_div = div;
      @(posedge clock); #1;
      c_mul = 0; c_div = 0; op_a = $urandom; op_b = $urandom;
   endtask

   task automatic wait_rdy(output int n);
      n = 0;
      do begin
         @(posedge clock); #1;
         n++;
      end while (!data_resultRDY && n < 40);
   endtask

   task automatic run(input string nm, input bit mul, input bit div, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] er, input bit ee, input int en);
      int n;
      start_op(mul, div, a, b);
      wait_rdy(n);
      chk({nm, "_latency"}, 32'(n), 32'(en));
      chk({nm, "_result"}, data_result, er);
      chk({nm, "_exc"}, 32'(data_exception), 32'(ee));
      @(posedge clock); #1;
      chk({nm, "_rdy_one_cycle"}, 32'(data_resultRDY), 32'd0);
   endtask

   initial begin
      int n, seen;
      #2 reset_n = 1'b0;
      @(posedge clock); #1;
      chk_en = 1'b1;
      chk("reset_result", data_result, 32'd0);
      chk("reset_exc", 32'(data_exception), 32'd0);
      chk("reset_rdy", 32'(data_resultRDY), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;

      run("mul_7_m3",    1, 0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 33);
      run("mul_ovf",     1, 0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1, 33);
      run("div_m7_2",    0, 1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0, 33);
      run("div_by_zero", 0, 1, 32'd100,       32'd0,         32'd0,         1, EARLY ? 1 : 33);
      run("mul_min_min", 1, 0, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1, 33);
      run("mul_m1_m1",   1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         0, 33);
      run("div_min_m1",  0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 33);
      run("div_min_1",   0, 1, 32'h8000_0000, 32'd1,         32'h8000_0000, 0, 33);
      run("div_7_m2",    0, 1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, 33);
      run("both_mul_wins", 1, 1, 32'd6,       32'd3,         32'd18,        0, 33);

      // New start sampled in the DONE cycle.
      start_op(1, 0, 32'd2, 32'd3);
      wait_rdy(n);
      chk("b2b_first_result", data_result, 32'd6);
      start_op(1, 0, 32'hFFFF_FFFC, 32'd5);
      wait_rdy(n);
      chk("b2b_second_latency", 32'(n), 32'd33);
      chk("b2b_second_result", data_result, 32'hFFFF_FFEC);

      // Abort a multiply with a divide on the 10th edge.
      start_op(1, 0, 32'd5, 32'd5);
      repeat (9) @(posedge clock);
      #1;
      start_op(0, 1, 32'd100, 32'd7);
      wait_rdy(n);
      chk("abort_latency", 32'(n), 32'd33);
      chk("abort_result", data_result, 32'd14);
      chk("abort_exc", 32'(data_exception), 32'd0);

      // Reset in the middle of a multiply.
      start_op(1, 0, 32'd3, 32'd4);
      repeat (14) @(posedge clock);
      #1;
      reset_n = 1'b0;
      #1;
      chk("midreset_result", data_result, 32'd0);
      chk("midreset_exc", 32'(data_exception), 32'd0);
      chk("midreset_rdy", 32'(data_resultRDY), 32'd0);
      chk("midreset_busy", 32'(busy), 32'd0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      seen = 0;
      repeat (40) begin
         @(posedge clock); #1;
         if (data_resultRDY) seen++;
      end
      chk("midreset_no_rdy", 32'(seen), 32'd0);
      run("after_reset_3x4", 1, 0, 32'd3, 32'd4, 32'd12, 0, 33);

      repeat (2) @(posedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/multdiv.md
Name: multdiv

Overview:
- Iterative signed 32-bit multiply/divide unit in the execute stage, beside the ALU.
- Consumes the same latched operands as the ALU and produces a result for the execute/memory pipeline latch.
- Multi-cycle: radix-2 Booth multiply, non-restoring divide, one iteration per clock.
- Pipeline stalls while the unit is busy.

Parameters:
- WIDTH, 32, operand/result width (only 32 is supported).
- ITERS, 32, iterations per operation; equals WIDTH.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- data_operandA  input  32  multiplicand / dividend (signed)
- data_operandB  input  32  multiplier / divisor (signed)
- ctrl_MULT  input  1  one-cycle start pulse for multiply
- ctrl_DIV  input  1  one-cycle start pulse for divide
- data_result  output  32  product low word / quotient
- data_exception  output  1  overflow or divide-by-zero flag, valid with data_resultRDY
- data_resultRDY  output  1  one-cycle completion pulse
- busy  output  1  high while an operation is in flight

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (reset_n).
  - Asserting reset_n low forces state IDLE, counter 0, data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - This applies at any time, including mid-operation.
- States: IDLE, MULT, DIV, DONE.
- Start:
  - A start is sampled on a rising edge with ctrl_MULT or ctrl_DIV high; operands are captured on that edge.
  - If both pulses are high together, ctrl_MULT wins.
  - A start in any state, including MULT or DIV, aborts the current operation and restarts with the new operands. The aborted operation never produces data_resultRDY.
- MULT:
  - Booth radix-2 on a 65-bit {acc, multiplier, q-1} register.
  - Each iteration adds, subtracts or does nothing per the bit pair, then arithmetic-shifts right one.
- DIV:
  - Non-restoring divide on magnitudes.
  - Quotient sign = signA XOR signB; truncates toward zero. The remainder is discarded.
- Counter: counts 0..ITERS-1. After the iteration with count=ITERS-1, the next edge enters DONE.
- Latency:
  - data_resultRDY is high for exactly one cycle, in the cycle after the 33rd rising edge following the start edge.
  - data_result and data_exception update on that same edge.
- DONE: lasts one cycle, then goes to IDLE, unless a new start is sampled, in which case it goes to MULT or DIV.
- Output hold: data_result and data_exception hold their values until the next completion or reset.
- busy: high from the edge after a start through the last iteration; low in DONE and IDLE.
- Multiply exception: set when the 64-bit product's upper 32 bits differ from sign-extension of product bit 31. data_result is still the low 32 bits.
- Divide by zero (B=0): data_result=0, data_exception=1, normal 33-edge latency.
- Divide 0x80000000 / 0xFFFFFFFF: data_result=0x80000000, data_exception=1.
- Adder: all add/subtract in both modes uses one shared 32-bit adder; no separate subtractor.
- Operand inputs are ignored except on start edges.

Optional Feature:
- Macro: MULTDIV_EARLY_TERM_EN.
- When defined: a divide with data_operandB==0 goes straight from the start edge to DONE. data_resultRDY asserts after the 1st edge following start, with data_result=0 and data_exception=1. Multiply is unaffected.
- When undefined: divide-by-zero takes the full 33-edge latency, as above.

Decomposition:
- Shared package multdiv_pkg holds:
  - state enum multdiv_state_t {IDLE, MULT, DIV, DONE}
  - constants WIDTH=32, ITERS=32, CNT_W=6
  - Booth op encoding {NOP, ADD, SUB}
- Sub-module multdiv_counter: 6-bit iteration counter with clear/enable and a terminal flag at ITERS-1.
- Adder: existing 32-bit carry-lookahead adder, instantiated once; carry-in=1 plus inverted B for subtract.

Test Plan:
- ctrl_MULT with A=7, B=0xFFFFFFFD -> after 33 edges: data_resultRDY=1 for one cycle, data_result=0xFFFFFFEB, data_exception=0.
- ctrl_MULT with A=0x00010000, B=0x00010000 -> data_result=0x00000000, data_exception=1 at edge 33.
- ctrl_DIV with A=0xFFFFFFF9 (-7), B=2 -> data_result=0xFFFFFFFD, data_exception=0.
- ctrl_DIV with A=100, B=0 -> data_result=0, data_exception=1:
  - at edge 33 without MULTDIV_EARLY_TERM_EN
  - at edge 1 with it
- ctrl_MULT A=5, B=5, then ctrl_DIV A=100, B=7 at edge 10 -> exactly one data_resultRDY, 33 edges after the DIV start, data_result=14.
- ctrl_MULT A=3, B=4, reset_n low for one cycle at edge 15 -> outputs immediately 0, data_resultRDY never asserts, busy=0; a following ctrl_MULT A=3, B=4 yields 12.
